// File: rtl/if_pkg.sv
// Shared widths, constants and FSM encoding for the instruction prefetch unit.
package if_pkg;

  localparam int          ADDR_W_DEF = 32;
  localparam int          INST_W_DEF = 32;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam int          INST_STEP  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fifo.sv
// Circular queue with flush; rd_data is the head entry, zero while empty.
// Push is visible one cycle later; a push while full is taken only if a pop frees a slot.
module if_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: one i-cache request in flight, returns queued for decode.
// out_valid one cycle after resp_valid; issue stops while queued + in-flight reaches DEPTH.
module if_prefetch
  import if_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_inst,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready
);

  localparam int              CW        = $clog2(DEPTH + 1);
  localparam int              EW        = ADDR_W + INST_W;
  localparam logic [CW:0]     DEPTH_OCC = (CW + 1)'(DEPTH);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              empty;
  logic              fire;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;

  // The in-flight request already owns a queue slot, so a response can always be pushed.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, (state == ST_WAIT)};
  assign req_addr  = fetch_pc;
  assign req_valid = rst_n && (state == ST_IDLE) && !redirect_valid && (occupancy < DEPTH_OCC);
  assign fire      = req_valid && req_ready;
  assign push      = (state == ST_WAIT) && resp_valid && !redirect_valid;
  assign pop       = !empty && out_ready && !redirect_valid;
  assign out_valid = !empty;
  assign {out_pc, out_inst} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fire) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (resp_valid)          state_nxt = ST_IDLE;
        else if (redirect_valid) state_nxt = ST_DROP;
      end
      ST_DROP: if (resp_valid) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      if (redirect_valid) fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (fire)      fetch_pc <= fetch_pc + ADDR_W'(INST_STEP);
      if (fire) req_pc <= fetch_pc;
    end
  end

  if_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({req_pc, resp_inst}),
    .pop       (pop),
    .flush     (redirect_valid),
    .rd_data   (head),
    .count     (count),
    .empty     (empty)
  );

endmodule
